// File: rtl/ex_lsu_pkg.sv
// Shared definitions for the EX-stage load/store unit: ALU op codes, bus size codes,
// pipeline control levels, FSM state encoding and the virtual-to-physical mapping.
package ex_lsu_pkg;

    typedef logic [7:0] aluop_t;

    localparam aluop_t EXE_LB_OP  = 8'b1110_0000;
    localparam aluop_t EXE_LH_OP  = 8'b1110_0001;
    localparam aluop_t EXE_LW_OP  = 8'b1110_0011;
    localparam aluop_t EXE_LBU_OP = 8'b1110_0100;
    localparam aluop_t EXE_LHU_OP = 8'b1110_0101;
    localparam aluop_t EXE_SB_OP  = 8'b1110_1000;
    localparam aluop_t EXE_SH_OP  = 8'b1110_1001;
    localparam aluop_t EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic FLUSH_ENABLE = 1'b1;
    localparam logic NO_STOP      = 1'b0;
    localparam int   STALL_EX_BIT = 2;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_REQ    = 3'd1,
        LSU_WAIT   = 3'd2,
        LSU_DONE   = 3'd3,
        LSU_CANCEL = 3'd4
    } lsu_state_e;

    // kseg0/kseg1 both alias the low 512 MB of physical memory.
    function automatic logic [31:0] lsu_v2p(input logic [31:0] vaddr, input logic map_kseg);
        if (map_kseg && (vaddr[31:30] == 2'b10)) begin
            return {3'b000, vaddr[28:0]};
        end
        return vaddr;
    endfunction

endpackage

// File: rtl/ex_lsu_if.sv
// SRAM-like data bus: one request phase (req/addr_ok) followed by one response phase (data_ok).
interface ex_lsu_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );

endinterface

// File: rtl/ex_lsu_store_fmt.sv
// Decodes the EX memory op into bus size, byte strobes, replicated store data and
// the natural-alignment check. Purely combinational.
module ex_lsu_store_fmt
    import ex_lsu_pkg::*;
(
    input  aluop_t      aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rt_i,
    output logic        is_mem_o,
    output logic        is_store_o,
    output logic [1:0]  size_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o
);

    logic [1:0] size_sel;

    always_comb begin
        is_mem_o   = 1'b1;
        is_store_o = 1'b0;
        size_sel   = SIZE_BYTE;
        wstrb_o    = 4'b0000;
        wdata_o    = 32'h0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: size_sel = SIZE_BYTE;
            EXE_LH_OP, EXE_LHU_OP: size_sel = SIZE_HALF;
            EXE_LW_OP:             size_sel = SIZE_WORD;
            EXE_SB_OP: begin
                is_store_o = 1'b1;
                size_sel   = SIZE_BYTE;
                wstrb_o    = 4'b0001 << addr_lo_i;
                wdata_o    = {4{rt_i[7:0]}};
            end
            EXE_SH_OP: begin
                is_store_o = 1'b1;
                size_sel   = SIZE_HALF;
                wstrb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{rt_i[15:0]}};
            end
            EXE_SW_OP: begin
                is_store_o = 1'b1;
                size_sel   = SIZE_WORD;
                wstrb_o    = 4'b1111;
                wdata_o    = rt_i;
            end
            default: is_mem_o = 1'b0;
        endcase
    end

    always_comb begin
        misalign_o = 1'b0;
        if (is_mem_o) begin
            case (size_sel)
                SIZE_HALF: misalign_o = addr_lo_i[0];
                SIZE_WORD: misalign_o = |addr_lo_i;
                default:   misalign_o = 1'b0;
            endcase
        end
    end

    assign size_o = size_sel;

endmodule

// File: rtl/ex_lsu.sv
// EX-stage load/store unit: issues one data bus transfer per memory op, stalls the
// pipeline while it is outstanding and holds the raw read word until ex_mem takes it.
module ex_lsu
    import ex_lsu_pkg::*;
#(
    parameter logic MAP_KSEG = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  aluop_t      aluop_i,
    input  logic [31:0] mem_vaddr_i,
    input  logic [31:0] store_data_i,
    input  logic        flush,
    input  logic [3:0]  stall_i,
    ex_lsu_if.master    bus,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_rdata_o,
    output logic        stallreq_o,
    output logic        exc_adel_o,
    output logic        exc_ades_o
);

    lsu_state_e  state_q, state_d;
    logic        acked_q, acked_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_mem, is_store, misalign, start;
    logic [1:0]  fmt_size;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_wdata;
    logic        flush_now;
    logic        unused_stall;

    ex_lsu_store_fmt u_fmt (
        .aluop_i    (aluop_i),
        .addr_lo_i  (mem_vaddr_i[1:0]),
        .rt_i       (store_data_i),
        .is_mem_o   (is_mem),
        .is_store_o (is_store),
        .size_o     (fmt_size),
        .wstrb_o    (fmt_wstrb),
        .wdata_o    (fmt_wdata),
        .misalign_o (misalign)
    );

    assign flush_now    = (flush == FLUSH_ENABLE);
    assign unused_stall = ^{stall_i[3], stall_i[1:0]};
    assign start        = (state_q == LSU_IDLE) && is_mem && !misalign && !flush_now;

    always_comb begin
        state_d = state_q;
        acked_d = acked_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    state_d = LSU_REQ;
                    acked_d = 1'b0;
                    wr_d    = is_store;
                    size_d  = fmt_size;
                    addr_d  = lsu_v2p(mem_vaddr_i, MAP_KSEG);
                    wstrb_d = fmt_wstrb;
                    wdata_d = fmt_wdata;
                end
            end
            LSU_REQ: begin
                // A request already on the bus cannot be withdrawn; a flush turns it into a drain.
                if (flush_now) begin
                    state_d = LSU_CANCEL;
                    acked_d = bus.data_addr_ok;
                end else if (bus.data_addr_ok) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (flush_now) begin
                    state_d = bus.data_data_ok ? LSU_IDLE : LSU_CANCEL;
                    acked_d = 1'b1;
                end else if (bus.data_data_ok) begin
                    state_d = LSU_DONE;
                    rdata_d = bus.data_rdata;
                end
            end
            LSU_DONE: begin
                if (flush_now || (stall_i[STALL_EX_BIT] == NO_STOP)) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_CANCEL: begin
                if (!acked_q) begin
                    acked_d = bus.data_addr_ok;
                end else if (bus.data_data_ok) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= LSU_IDLE;
            acked_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            acked_q <= acked_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.data_req   = (state_q == LSU_REQ) || ((state_q == LSU_CANCEL) && !acked_q);
    assign bus.data_wr    = wr_q;
    assign bus.data_size  = size_q;
    assign bus.data_addr  = addr_q;
    assign bus.data_wstrb = wstrb_q;
    assign bus.data_wdata = wdata_q;

    assign data_addr_o  = mem_vaddr_i;
    assign data_rdata_o = rdata_q;
    assign stallreq_o   = resetn && (start || (state_q == LSU_REQ) || (state_q == LSU_WAIT)
                                           || (state_q == LSU_CANCEL));
    assign exc_adel_o   = resetn && is_mem && !is_store && misalign;
    assign exc_ades_o   = resetn && is_mem && is_store && misalign;

endmodule

// File: tb/tb_ex_lsu.sv
// Bench for ex_lsu: directed table of memory ops, hand-written flush/reset sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_ex_lsu;
    import ex_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    aluop_t      aluop;
    logic [31:0] vaddr, sdata;
    logic        flush;
    logic [3:0]  stall;
    logic [31:0] data_addr_o, data_rdata_o;
    logic        stallreq_o, exc_adel_o, exc_ades_o;

    ex_lsu_if bus();

    ex_lsu #(.MAP_KSEG(1'b1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .aluop_i      (aluop),
        .mem_vaddr_i  (vaddr),
        .store_data_i (sdata),
        .flush        (flush),
        .stall_i      (stall),
        .bus          (bus),
        .data_addr_o  (data_addr_o),
        .data_rdata_o (data_rdata_o),
        .stallreq_o   (stallreq_o),
        .exc_adel_o   (exc_adel_o),
        .exc_ades_o   (exc_ades_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        aluop_t      op;
        logic [31:0] va, rt;
        int          alat, dlat, hold;
        logic [31:0] rd;
        logic        mem, wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        adel, ades;
    } vec_t;

    localparam aluop_t OP_ADDU = 8'b0010_0001;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] last_rd = 32'h0;
    vec_t        vecs[13];
    aluop_t      ops[9] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, OP_ADDU};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t tv(aluop_t op, logic [31:0] va, logic [31:0] rt, int alat, int dlat,
                                int hold, logic [31:0] rd, logic mem, logic wr, logic [31:0] addr,
                                logic [1:0] size, logic [3:0] wstrb, logic [31:0] wdata,
                                logic adel, logic ades);
        vec_t v;
        v = '{op, va, rt, alat, dlat, hold, rd, mem, wr, addr, size, wstrb, wdata, adel, ades};
        return v;
    endfunction

    // Reference: expectations from access width, address arithmetic and byte replication.
    function automatic vec_t model(aluop_t op, logic [31:0] va, logic [31:0] rt);
        vec_t v;
        int   nb;
        v = tv(op, va, rt, 0, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0, 1'b0, 1'b0);
        nb = 0;
        if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) nb = 1;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) nb = 2;
        if (op == EXE_LW_OP || op == EXE_SW_OP) nb = 4;
        if (nb == 0) return v;
        v.mem  = 1'b1;
        v.wr   = (op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP);
        v.size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        v.addr = (va >= 32'h8000_0000 && va < 32'hC000_0000) ? va % 32'h2000_0000 : va;
        if (v.wr) begin
            v.wstrb = 4'(((1 << nb) - 1) << (va % 4));
            v.wdata = (nb == 1) ? (rt % 256) * 32'h0101_0101 :
                      (nb == 2) ? (rt % 65536) * 32'h0001_0001 : rt;
        end
        if ((va % nb) != 0) begin
            v.adel = !v.wr;
            v.ades = v.wr;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one op from IDLE through DONE (or the rejected path) with scripted bus latencies.
    task automatic xact(input vec_t v);
        aluop = v.op; vaddr = v.va; sdata = v.rt;
        flush = 1'b0; stall = 4'b0000;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        $display("xact op=%02h va=%08h rt=%08h alat=%0d dlat=%0d hold=%0d",
                 v.op, v.va, v.rt, v.alat, v.dlat, v.hold);
        @(negedge clk);
        chk("adel", 32'(exc_adel_o), 32'(v.adel));
        chk("ades", 32'(exc_ades_o), 32'(v.ades));
        chk("addr_o", data_addr_o, v.va);
        if (!v.mem || v.adel || v.ades) begin
            chk("rej_stall", 32'(stallreq_o), 32'd0);
            chk("rej_req", 32'(bus.data_req), 32'd0);
            step();
            @(negedge clk);
            chk("rej_req2", 32'(bus.data_req), 32'd0);
            step();
            aluop = OP_ADDU;
            return;
        end
        chk("idle_stall", 32'(stallreq_o), 32'd1);
        chk("idle_req", 32'(bus.data_req), 32'd0);
        step();
        for (int k = 0; k <= v.alat; k++) begin
            bus.data_addr_ok = (k == v.alat);
            if (k > 0) begin
                vaddr = $urandom; sdata = $urandom;
            end
            @(negedge clk);
            chk("req", 32'(bus.data_req), 32'd1);
            chk("req_stall", 32'(stallreq_o), 32'd1);
            chk("bus_addr", bus.data_addr, v.addr);
            chk("bus_size", 32'(bus.data_size), 32'(v.size));
            chk("bus_wr", 32'(bus.data_wr), 32'(v.wr));
            chk("bus_wstrb", 32'(bus.data_wstrb), 32'(v.wstrb));
            if (v.wr) chk("bus_wdata", bus.data_wdata, v.wdata);
            step();
        end
        bus.data_addr_ok = 1'b0;
        for (int k = 0; k <= v.dlat; k++) begin
            bus.data_data_ok = (k == v.dlat);
            bus.data_rdata   = (k == v.dlat) ? v.rd : $urandom;
            @(negedge clk);
            chk("wait_req", 32'(bus.data_req), 32'd0);
            chk("wait_stall", 32'(stallreq_o), 32'd1);
            step();
        end
        bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        vaddr = v.va; sdata = v.rt;
        for (int k = 0; k <= v.hold; k++) begin
            stall = (k < v.hold) ? 4'b1100 : 4'b0000;
            @(negedge clk);
            chk("done_stall", 32'(stallreq_o), 32'd0);
            chk("done_req", 32'(bus.data_req), 32'd0);
            chk("rdata_o", data_rdata_o, v.rd);
            step();
        end
        last_rd = v.rd;
        stall = 4'b0000; aluop = OP_ADDU;
    endtask

    initial begin
        resetn = 1'b0; aluop = OP_ADDU; vaddr = 32'h0; sdata = 32'h0;
        flush = 1'b0; stall = 4'b0000;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;

        vecs[0]  = tv(EXE_LW_OP,  32'h8000_0010, 32'h0,         0, 0, 0, 32'hDEAD_BEEF,
                      1, 0, 32'h0000_0010, 2, 4'h0, 32'h0, 0, 0);
        vecs[1]  = tv(EXE_SB_OP,  32'hA000_0003, 32'h0000_00A5, 5, 1, 0, 32'h1111_1111,
                      1, 1, 32'h0000_0003, 0, 4'b1000, 32'hA5A5_A5A5, 0, 0);
        vecs[2]  = tv(EXE_LH_OP,  32'h8000_0001, 32'h0,         0, 0, 0, 32'h0,
                      1, 0, 32'h0, 1, 4'h0, 32'h0, 1, 0);
        vecs[3]  = tv(EXE_SW_OP,  32'h8000_0002, 32'h1234_5678, 0, 0, 0, 32'h0,
                      1, 1, 32'h0, 2, 4'h0, 32'h0, 0, 1);
        vecs[4]  = tv(EXE_SH_OP,  32'h0040_0006, 32'h1234_BEEF, 1, 2, 2, 32'h2222_2222,
                      1, 1, 32'h0040_0006, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0);
        vecs[5]  = tv(EXE_LBU_OP, 32'hBFC0_0001, 32'h0,         0, 3, 1, 32'h3333_3333,
                      1, 0, 32'h1FC0_0001, 0, 4'h0, 32'h0, 0, 0);
        vecs[6]  = tv(EXE_LHU_OP, 32'hC000_0002, 32'h0,         2, 0, 0, 32'h4444_4444,
                      1, 0, 32'hC000_0002, 1, 4'h0, 32'h0, 0, 0);
        vecs[7]  = tv(EXE_SW_OP,  32'h9000_0008, 32'hCAFE_F00D, 0, 0, 2, 32'h5555_5555,
                      1, 1, 32'h1000_0008, 2, 4'b1111, 32'hCAFE_F00D, 0, 0);
        vecs[8]  = tv(EXE_SB_OP,  32'h8000_0000, 32'h0000_0012, 0, 0, 0, 32'h7777_7777,
                      1, 1, 32'h0000_0000, 0, 4'b0001, 32'h1212_1212, 0, 0);
        vecs[9]  = tv(EXE_LB_OP,  32'h0000_0007, 32'h0,         1, 1, 0, 32'h8888_8888,
                      1, 0, 32'h0000_0007, 0, 4'h0, 32'h0, 0, 0);
        vecs[10] = tv(OP_ADDU,    32'h8000_0010, 32'h0,         0, 0, 0, 32'h0,
                      0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
        vecs[11] = tv(EXE_SH_OP,  32'h8000_0003, 32'hFFFF,      0, 0, 0, 32'h0,
                      1, 1, 32'h0, 1, 4'h0, 32'h0, 0, 1);
        vecs[12] = tv(EXE_LW_OP,  32'h8000_000C, 32'h0,         0, 0, 2, 32'h6666_6666,
                      1, 0, 32'h0000_000C, 2, 4'h0, 32'h0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_wr", 32'(bus.data_wr), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_adel", 32'(exc_adel_o), 32'd0);
        chk("rst_ades", 32'(exc_ades_o), 32'd0);
        chk("rst_rdata", data_rdata_o, 32'h0);
        chk("rst_addr", bus.data_addr, 32'h0);
        chk("rst_wdata", bus.data_wdata, 32'h0);
        chk("rst_wstrb", 32'(bus.data_wstrb), 32'h0);
        chk("rst_size", 32'(bus.data_size), 32'h0);
        resetn = 1'b1;
        step();

        foreach (vecs[i]) xact(vecs[i]);

        // Flush while waiting for data: the response is drained and discarded, next LW waits.
        $display("seq flush_in_wait");
        aluop = EXE_LW_OP; vaddr = 32'h8000_0020;
        step();
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("fw_stall", 32'(stallreq_o), 32'd1);
        step();
        flush = 1'b0; aluop = EXE_LW_OP; vaddr = 32'h8000_0040;
        @(negedge clk);
        chk("fw_drain_req", 32'(bus.data_req), 32'd0);
        chk("fw_drain_stall", 32'(stallreq_o), 32'd1);
        step();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fw_drain_req2", 32'(bus.data_req), 32'd0);
        step();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("fw_rdata_kept", data_rdata_o, last_rd);
        chk("fw_idle_stall", 32'(stallreq_o), 32'd1);
        step();
        @(negedge clk);
        chk("fw_next_req", 32'(bus.data_req), 32'd1);
        chk("fw_next_addr", bus.data_addr, 32'h0000_0040);
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_F00D;
        step();
        bus.data_data_ok = 1'b0; aluop = OP_ADDU;
        @(negedge clk);
        chk("fw_next_rdata", data_rdata_o, 32'h0BAD_F00D);
        last_rd = 32'h0BAD_F00D;
        step();

        // Flush before addr_ok: request stays up until accepted, then the response is drained.
        $display("seq flush_in_req");
        aluop = EXE_SW_OP; vaddr = 32'h8000_0100; sdata = 32'h0102_0304;
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("fr_req", 32'(bus.data_req), 32'd1);
        step();
        flush = 1'b0; aluop = OP_ADDU;
        @(negedge clk);
        chk("fr_req_kept", 32'(bus.data_req), 32'd1);
        chk("fr_addr_kept", bus.data_addr, 32'h0000_0100);
        chk("fr_stall", 32'(stallreq_o), 32'd1);
        step();
        bus.data_addr_ok = 1'b1;
        step();
        bus.data_addr_ok = 1'b0;
        @(negedge clk);
        chk("fr_req_drop", 32'(bus.data_req), 32'd0);
        chk("fr_stall2", 32'(stallreq_o), 32'd1);
        step();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_0000;
        step();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        chk("fr_idle_stall", 32'(stallreq_o), 32'd0);
        chk("fr_rdata_kept", data_rdata_o, last_rd);
        step();

        // Reset in the middle of a request.
        $display("seq reset_in_req");
        aluop = EXE_SW_OP; vaddr = 32'h8000_0004; sdata = 32'h55;
        step();
        resetn = 1'b0; aluop = OP_ADDU;
        step();
        @(negedge clk);
        chk("mr_req", 32'(bus.data_req), 32'd0);
        chk("mr_addr", bus.data_addr, 32'h0);
        chk("mr_wr", 32'(bus.data_wr), 32'd0);
        chk("mr_stall", 32'(stallreq_o), 32'd0);
        resetn = 1'b1;
        step();
        last_rd = 32'h0;

        for (int n = 0; n < 60; n++) begin
            vec_t        v;
            aluop_t      op;
            logic [31:0] va;
            op = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0:       va = $urandom & 32'h7FFF_FFFF;
                1:       va = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
                2:       va = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
                default: va = 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
            endcase
            if ($urandom_range(0, 3) != 0) va = va & 32'hFFFF_FFFC;
            v = model(op, va, $urandom);
            v.alat = $urandom_range(0, 3);
            v.dlat = $urandom_range(0, 3);
            v.hold = $urandom_range(0, 2);
            v.rd   = $urandom;
            xact(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
